sobel_edge_stage: RTL and testbench

- Downstream consumer of the 3x3 window generator (MainModule).
- Takes one 3x3 pixel window per cycle (Out1..Out9 plus a per-window valid) and produces one 8-bit Sobel gradient-magnitude pixel per window through a 3-stage pipeline.
- Counts emitted pixels and pulses frame_done after the last pixel of a frame, for the result writer or testbench capture.

---
 rtl/sobel_edge_stage.sv | 83 ++++++++
 tb/tb_sobel_edge_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: 3-stage Sobel gradient-magnitude filter over a 3x3 window stream,
// with per-frame pixel counting and a frame_done pulse on the last pixel.
module sobel_edge_stage #(
    parameter int          NUM_PIX   = 64516,
    parameter bit          THRESH_EN = 1'b0,
    parameter logic [10:0] THRESH    = 11'd128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        win_valid,
    input  logic [7:0]  p1,
    input  logic [7:0]  p2,
    input  logic [7:0]  p3,
    input  logic [7:0]  p4,
    input  logic [7:0]  p5,
    input  logic [7:0]  p6,
    input  logic [7:0]  p7,
    input  logic [7:0]  p8,
    input  logic [7:0]  p9,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    output logic [15:0] pix_count,
    output logic        frame_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic acc, v1, v2;
    logic [10:0] gx, gy, gx_n, gy_n, mag;
    logic [9:0] ax, ay, ax_n, ay_n;
    logic [7:0] pix_n;

    assign acc = Start & win_valid;
    assign frame_done = pix_valid && (pix_count == 16'(NUM_PIX - 1));
    assign busy = (state == RUN);

    // 11-bit two's-complement arithmetic; wrap-around yields the signed gradient directly
    always_comb begin
        gx_n = ({3'b0, p3} + {2'b0, p6, 1'b0} + {3'b0, p9}) - ({3'b0, p1} + {2'b0, p4, 1'b0} + {3'b0, p7});
        gy_n = ({3'b0, p7} + {2'b0, p8, 1'b0} + {3'b0, p9}) - ({3'b0, p1} + {2'b0, p2, 1'b0} + {3'b0, p3});
        ax_n = gx[10] ? 10'(-gx) : gx[9:0];
        ay_n = gy[10] ? 10'(-gy) : gy[9:0];
        mag = {1'b0, ax} + {1'b0, ay};
        pix_n = THRESH_EN ? ((mag >= THRESH) ? 8'hFF : 8'h00) : ((mag > 11'd255) ? 8'hFF : mag[7:0]);
        state_n = state;
        case (state)
            IDLE:    state_n = acc ? RUN : IDLE;
            RUN:     state_n = frame_done ? DONE : RUN;
            default: state_n = acc ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            gx        <= '0;
            gy        <= '0;
            ax        <= '0;
            ay        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            pix_count <= '0;
        end else begin
            state     <= state_n;
            v1        <= acc;
            v2        <= v1;
            pix_valid <= v2;
            if (acc) begin
                gx <= gx_n;
                gy <= gy_n;
            end
            if (v1) begin
                ax <= ax_n;
                ay <= ay_n;
            end
            if (v2) pix_out <= pix_n;
            if (pix_valid) pix_count <= frame_done ? 16'd0 : pix_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb_sobel_edge_stage: directed checks of the Sobel stage; two instances share inputs,
// one saturating and one thresholded at 64, both with a 4-pixel frame.
module tb_sobel_edge_stage;
    logic CLK = 1'b0, RST = 1'b1, Start = 1'b0, win_valid = 1'b0;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [7:0] pix_out0, pix_out1;
    logic pix_valid0, pix_valid1, frame_done0, frame_done1, busy0, busy1;
    logic [15:0] pix_count0, pix_count1;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    sobel_edge_stage #(.NUM_PIX(4), .THRESH_EN(1'b0), .THRESH(11'd128)) d0 (
        .CLK(CLK), .RST(RST), .Start(Start), .win_valid(win_valid),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .pix_out(pix_out0), .pix_valid(pix_valid0), .pix_count(pix_count0),
        .frame_done(frame_done0), .busy(busy0));

    sobel_edge_stage #(.NUM_PIX(4), .THRESH_EN(1'b1), .THRESH(11'd64)) d1 (
        .CLK(CLK), .RST(RST), .Start(Start), .win_valid(win_valid),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .pix_out(pix_out1), .pix_valid(pix_valid1), .pix_count(pix_count1),
        .frame_done(frame_done1), .busy(busy1));

    task automatic set_win(input logic [71:0] w);
        {p1, p2, p3, p4, p5, p6, p7, p8, p9} = w;
    endtask

    // one window for one cycle, then return after the third rising edge
    task automatic send(input logic [71:0] w);
        @(negedge CLK);
        set_win(w);
        win_valid = 1'b1;
        @(negedge CLK);
        win_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        set_win('0);
        #12;
        checks += 5;
        if (pix_out0 !== 8'd0) begin errors++; $display("FAIL reset pix_out got %0d want 0", pix_out0); end
        if (pix_valid0 !== 1'b0) begin errors++; $display("FAIL reset pix_valid got %b want 0", pix_valid0); end
        if (pix_count0 !== 16'd0) begin errors++; $display("FAIL reset pix_count got %0d want 0", pix_count0); end
        if (frame_done0 !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b want 0", frame_done0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy0); end
        @(negedge CLK);
        RST = 1'b0;
        Start = 1'b1;
    endtask

    task automatic test_flat;
        @(negedge CLK);
        set_win({9{8'd100}});
        win_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            win_valid = 1'b0;
            checks++;
            if (pix_valid0 !== (i == 3)) begin errors++; $display("FAIL flat_latency cyc %0d pix_valid got %b want %b", i, pix_valid0, i == 3); end
            if (i == 3) begin
                checks += 3;
                if (pix_out0 !== 8'd0) begin errors++; $display("FAIL flat_out got %0d want 0", pix_out0); end
                if (pix_out1 !== 8'd0) begin errors++; $display("FAIL flat_thr got %0d want 0", pix_out1); end
                if (busy0 !== 1'b1) begin errors++; $display("FAIL flat_busy got %b want 1", busy0); end
            end
        end
    endtask

    task automatic test_vertical;
        send({3{8'd0, 8'd128, 8'd255}});
        checks += 3;
        if (pix_valid0 !== 1'b1) begin errors++; $display("FAIL vert_valid got %b want 1", pix_valid0); end
        if (pix_out0 !== 8'd255) begin errors++; $display("FAIL vert_sat got %0d want 255", pix_out0); end
        if (pix_out1 !== 8'd255) begin errors++; $display("FAIL vert_thr got %0d want 255", pix_out1); end
    endtask

    task automatic test_diag;
        send({16'd0, 8'd10, 48'd0});
        checks += 2;
        if (pix_out0 !== 8'd20) begin errors++; $display("FAIL diag10_mag got %0d want 20", pix_out0); end
        if (pix_out1 !== 8'd0) begin errors++; $display("FAIL diag10_thr got %0d want 0", pix_out1); end
        send({16'd0, 8'd40, 48'd0});
        checks += 2;
        if (pix_out0 !== 8'd80) begin errors++; $display("FAIL diag40_mag got %0d want 80", pix_out0); end
        if (pix_out1 !== 8'd255) begin errors++; $display("FAIL diag40_thr got %0d want 255", pix_out1); end
        @(negedge CLK);
        checks++;
        if (pix_out0 !== 8'd80 || pix_valid0 !== 1'b0) begin errors++; $display("FAIL hold got %0d/%b want 80/0", pix_out0, pix_valid0); end
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            checks += 3;
            if (pix_valid0 !== (i >= 3 && i <= 8)) begin errors++; $display("FAIL b2b_valid i=%0d got %b want %b", i, pix_valid0, i >= 3 && i <= 8); end
            if (frame_done0 !== (i == 6)) begin errors++; $display("FAIL b2b_done i=%0d got %b want %b", i, frame_done0, i == 6); end
            if (busy0 !== (i >= 1 && i <= 6)) begin errors++; $display("FAIL b2b_busy i=%0d got %b want %b", i, busy0, i >= 1 && i <= 6); end
            if (i >= 3 && i <= 8) begin
                checks += 2;
                if (pix_count0 !== 16'((i - 3) % 4)) begin errors++; $display("FAIL b2b_count i=%0d got %0d want %0d", i, pix_count0, (i - 3) % 4); end
                if (pix_out0 !== 8'(20 * (i - 2))) begin errors++; $display("FAIL b2b_out i=%0d got %0d want %0d", i, pix_out0, 20 * (i - 2)); end
            end
            set_win({16'd0, 8'(10 * (i + 1)), 48'd0});
            win_valid = (i < 6);
        end
        @(negedge CLK);
        set_win({16'd0, 8'd10, 48'd0});
        win_valid = 1'b1;
        @(negedge CLK);
        win_valid = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL rerise_busy got %b want 1", busy0); end
        @(negedge CLK);
        @(negedge CLK);
        checks += 3;
        if (pix_valid0 !== 1'b1) begin errors++; $display("FAIL rerise_valid got %b want 1", pix_valid0); end
        if (pix_count0 !== 16'd2) begin errors++; $display("FAIL rerise_count got %0d want 2", pix_count0); end
        if (pix_out0 !== 8'd20) begin errors++; $display("FAIL rerise_out got %0d want 20", pix_out0); end
    endtask

    task automatic test_start_gate;
        @(negedge CLK);
        Start = 1'b0;
        set_win({16'd0, 8'd50, 48'd0});
        win_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 4) win_valid = 1'b0;
            checks++;
            if (pix_valid0 !== 1'b0) begin errors++; $display("FAIL gate_idle i=%0d got %b want 0", i, pix_valid0); end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            checks++;
            if (pix_valid0 !== (i == 3 || i == 4)) begin errors++; $display("FAIL drain_valid i=%0d got %b want %b", i, pix_valid0, i == 3 || i == 4); end
            if (i == 3 || i == 4) begin
                checks++;
                if (pix_out0 !== ((i == 3) ? 8'd20 : 8'd80)) begin errors++; $display("FAIL drain_out i=%0d got %0d want %0d", i, pix_out0, (i == 3) ? 20 : 80); end
            end
            Start = (i < 2);
            set_win({16'd0, (i == 0) ? 8'd10 : 8'd40, 48'd0});
            win_valid = 1'b1;
        end
        win_valid = 1'b0;
    endtask

    task automatic test_async_reset;
        @(negedge CLK);
        Start = 1'b1;
        set_win({16'd0, 8'd30, 48'd0});
        win_valid = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        win_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks += 4;
        if (pix_out0 !== 8'd0) begin errors++; $display("FAIL arst_out got %0d want 0", pix_out0); end
        if (pix_count0 !== 16'd0) begin errors++; $display("FAIL arst_count got %0d want 0", pix_count0); end
        if (pix_valid0 !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", pix_valid0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy0); end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++;
            if (pix_valid0 !== 1'b0) begin errors++; $display("FAIL arst_flush i=%0d got %b want 0", i, pix_valid0); end
        end
    endtask

    initial begin
        test_reset;
        test_flat;
        test_vertical;
        test_diag;
        test_back_to_back;
        test_start_gate;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
